regfile_access_ctrl: RTL

//  Initiator-side controller for the 1024x32 register/memory block. Accepts

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_access_ctrl_if.sv | 41 ++++
 rtl/regfile_access_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings and default widths for the register-file access controller.
// Imported by the controller, its bus interface and the testbench.
package regfile_pkg;

  localparam int RF_AW = 10;
  localparam int RF_DW = 32;
  localparam int RF_KW = 16;

  typedef enum logic [1:0] {
    OP_READ_PAIR = 2'd0,
    OP_WRITE     = 2'd1,
    OP_FILL      = 2'd2,
    OP_RSVD      = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_CAPT = 3'd2,
    ST_WR      = 3'd3,
    ST_FILL    = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Command and response channels between a command source and the controller.
// Handshake: a beat transfers on a posedge where valid & ready are both high;
// the sender holds valid and its payload stable until that edge.
interface regfile_access_ctrl_if
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW,
  parameter int KW = RF_KW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_addr2;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic [KW-1:0] cmd_key;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_len, cmd_data, cmd_key,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_data1, rsp_data2, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_len, cmd_data, cmd_key,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_data1, rsp_data2, rsp_err
  );

endinterface

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for the 1024x32 register/memory block: turns
// read-pair, write and fill commands into memory port activity and responses.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW,
  parameter int KW = RF_KW
)
(
  input  logic                  clk,
  input  logic                  rst,
  regfile_access_ctrl_if.slave  bus,
  output logic [AW-1:0]         mem_reg1,
  output logic [AW-1:0]         mem_reg2,
  output logic [AW-1:0]         mem_address,
  output logic [DW-1:0]         mem_write_data,
  output logic                  mem_read_enable,
  input  logic [DW-1:0]         mem_read_reg1,
  input  logic [DW-1:0]         mem_read_reg2,
  input  logic [KW-1:0]         mem_key_access,
  output state_e                dbg_state
);

  state_e        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data1_q, rsp_data1_d;
  logic [DW-1:0] rsp_data2_q, rsp_data2_d;
  logic          rsp_err_q, rsp_err_d;
  logic [AW-1:0] reg1_q, reg1_d;
  logic [AW-1:0] reg2_q, reg2_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          re_q, re_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;

  op_e  op;
  logic accept;
  logic key_ok;

  assign op     = op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && cmd_ready_q;
  assign key_ok = (bus.cmd_key == mem_key_access);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      rsp_err_q   <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      re_q        <= 1'b1;
      cnt_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
      rsp_err_q   <= rsp_err_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      re_q        <= re_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;
    rsp_err_d   = rsp_err_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    re_d        = re_q;
    cnt_d       = cnt_q;
    len_d       = len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          len_d       = bus.cmd_len;
          case (op)
            OP_READ_PAIR: begin
              reg1_d  = bus.cmd_addr;
              addr_d  = bus.cmd_addr;
              reg2_d  = bus.cmd_addr2;
              state_d = ST_RD_WAIT;
            end
            OP_WRITE, OP_FILL: begin
              if (key_ok) begin
                addr_d  = bus.cmd_addr;
                wdata_d = bus.cmd_data;
                re_d    = 1'b0;
                state_d = (op == OP_WRITE) ? ST_WR : ST_FILL;
              end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = ST_RESP;
              end
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              state_d     = ST_RESP;
            end
          endcase
        end
      end

      // Memory registers its read ports on this edge.
      ST_RD_WAIT: state_d = ST_RD_CAPT;

      ST_RD_CAPT: begin
        rsp_data1_d = mem_read_reg1;
        rsp_data2_d = mem_read_reg2;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_WR: begin
        re_d        = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end

      // One word per edge; the address wraps naturally at AW bits.
      ST_FILL: begin
        if (cnt_q == len_q) begin
          re_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d  = cnt_q + AW'(1);
          addr_d = addr_q + AW'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data1_d = '0;
          rsp_data2_d = '0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        re_d        = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data1   = rsp_data1_q;
  assign bus.rsp_data2   = rsp_data2_q;
  assign bus.rsp_err     = rsp_err_q;
  assign mem_reg1        = reg1_q;
  assign mem_reg2        = reg2_q;
  assign mem_address     = addr_q;
  assign mem_write_data  = wdata_q;
  assign mem_read_enable = re_q;
  assign dbg_state       = state_q;

endmodule
